// File: rtl/fad4_seq_arb_if.sv
// -----------------------------------------------------------------------------
// fad4_seq_arb_if
// Bundles the requester handshakes, operands and result bus of the
// nibble-serial add/subtract sequencer.
//
// Parameter:
//   NIB     : nibbles per operation, operand width W = 4*NIB
// Signals:
//   REQ0/1, SUB0/1, A0_IN/B0_IN, A1_IN/B1_IN : requester side -> sequencer
//   GNT0/1, BUSY, DONE, DONE_ID, S, CO, OVF   : sequencer -> requester side
// Modports:
//   master : the requester side (drives requests and operands)
//   slave  : the sequencer (drives grants and results)
// -----------------------------------------------------------------------------
interface fad4_seq_arb_if #(
  parameter int NIB = 4
) ();
  localparam int W = 4 * NIB;

  logic         REQ0;
  logic         REQ1;
  logic         SUB0;
  logic         SUB1;
  logic [W-1:0] A0_IN;
  logic [W-1:0] B0_IN;
  logic [W-1:0] A1_IN;
  logic [W-1:0] B1_IN;

  logic         GNT0;
  logic         GNT1;
  logic         BUSY;
  logic         DONE;
  logic         DONE_ID;
  logic [W-1:0] S;
  logic         CO;
  logic         OVF;

  modport master (
    output REQ0, REQ1, SUB0, SUB1, A0_IN, B0_IN, A1_IN, B1_IN,
    input  GNT0, GNT1, BUSY, DONE, DONE_ID, S, CO, OVF
  );

  modport slave (
    input  REQ0, REQ1, SUB0, SUB1, A0_IN, B0_IN, A1_IN, B1_IN,
    output GNT0, GNT1, BUSY, DONE, DONE_ID, S, CO, OVF
  );
endinterface

// File: rtl/fad4_seq_arb.sv
// -----------------------------------------------------------------------------
// fad4_seq_arb
// Nibble-serial add/subtract sequencer. Two requesters share one 4-bit
// full-add slice; a granted W-bit operation is pushed through the slice one
// nibble per clock, LSB first, with a registered carry between nibbles.
// Round-robin arbitration (1-bit pointer) picks between simultaneous requests.
//
// Optional feature macro: FAD4_SEQ_OVF_EN
//   defined   : OVF is the registered signed-overflow flag of the result
//   undefined : no overflow logic, OVF is tied to 0
//
// Parameter:
//   NIB : nibbles per operation (2..8), W = 4*NIB
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset, discards any in-flight operation
//   bus : fad4_seq_arb_if.slave
//         in  REQ0/1, SUB0/1, A0_IN/B0_IN, A1_IN/B1_IN
//         out GNT0/1 (1-cycle capture pulse), BUSY, DONE (1-cycle pulse),
//             DONE_ID, S, CO, OVF (held until the next DONE)
// -----------------------------------------------------------------------------
module fad4_seq_arb #(
  parameter int NIB = 4
) (
  input  logic           CLK,
  input  logic           RST,
  fad4_seq_arb_if.slave  bus
);
  localparam int W  = 4 * NIB;
  localparam int KW = $clog2(NIB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic          r_ptr;       // requester that wins a tie
  logic          r_owner;     // requester of the operation in flight
  logic [W-1:0]  r_a;         // shifts right one nibble per RUN cycle
  logic [W-1:0]  r_b;         // captured B, already inverted for SUB
  logic          r_carry;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_shift;     // sum nibbles enter at the top
  logic          r_gnt0;
  logic          r_gnt1;
  logic [W-1:0]  r_s;
  logic          r_co;
  logic          r_done_id;

  logic          w_any_req;
  logic          w_pick;
  logic          w_grant;
  logic          w_last;
  logic [3:0]    w_sum;
  logic          w_cout;

  // ---------------------------------------------------------------------------
  // Arbitration: only sampled in IDLE and DONE.
  // ---------------------------------------------------------------------------
  assign w_any_req = bus.REQ0 | bus.REQ1;
  assign w_pick    = (bus.REQ0 & bus.REQ1) ? r_ptr : bus.REQ1;
  assign w_grant   = w_any_req && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last    = (r_state == ST_RUN) && (r_k == KW'(NIB - 1));

  // ---------------------------------------------------------------------------
  // The shared 4-bit ripple full-add slice on the low nibbles.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic v_c;
    w_sum = 4'd0;
    v_c   = r_carry;
    for (int i = 0; i < 4; i++) begin
      w_sum[i] = r_a[i] ^ r_b[i] ^ v_c;
      v_c      = (r_a[i] & r_b[i]) | (v_c & (r_a[i] ^ r_b[i]));
    end
    w_cout = v_c;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: w_state_next = w_any_req ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_k       <= '0;
      r_shift   <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_s       <= '0;
      r_co      <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      if (w_grant) begin
        // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
        if (w_pick) begin
          r_a     <= bus.A1_IN;
          r_b     <= bus.SUB1 ? ~bus.B1_IN : bus.B1_IN;
          r_carry <= bus.SUB1;
          r_gnt1  <= 1'b1;
        end else begin
          r_a     <= bus.A0_IN;
          r_b     <= bus.SUB0 ? ~bus.B0_IN : bus.B0_IN;
          r_carry <= bus.SUB0;
          r_gnt0  <= 1'b1;
        end
        r_owner <= w_pick;
        r_ptr   <= ~w_pick;
        r_k     <= '0;
      end else if (r_state == ST_RUN) begin
        r_a     <= {4'd0, r_a[W-1:4]};
        r_b     <= {4'd0, r_b[W-1:4]};
        r_carry <= w_cout;
        r_shift <= {w_sum, r_shift[W-1:4]};
        r_k     <= r_k + KW'(1);
        if (w_last) begin
          r_s       <= {w_sum, r_shift[W-1:4]};
          r_co      <= w_cout;
          r_done_id <= r_owner;
        end
      end
    end
  end

`ifdef FAD4_SEQ_OVF_EN
  // On the last nibble r_a[3]/r_b[3] hold the operand sign bits and
  // w_sum[3] is the result sign bit.
  logic r_ovf;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_a[3] == r_b[3]) && (w_sum[3] != r_a[3]);
    end
  end
  assign bus.OVF = r_ovf;
`else
  assign bus.OVF = 1'b0;
`endif

  assign bus.GNT0    = r_gnt0;
  assign bus.GNT1    = r_gnt1;
  assign bus.BUSY    = (r_state != ST_IDLE);
  assign bus.DONE    = (r_state == ST_DONE);
  assign bus.DONE_ID = r_done_id;
  assign bus.S       = r_s;
  assign bus.CO      = r_co;
endmodule

// File: tb/tb_fad4_seq_arb.sv
// -----------------------------------------------------------------------------
// tb_fad4_seq_arb
// Directed bench for fad4_seq_arb (NIB=4). Expected results are pushed into
// a scoreboard queue when each operation is issued; a monitor pops and
// compares every time DONE is seen. Handshake timing is checked inline.
// -----------------------------------------------------------------------------
module tb_fad4_seq_arb;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
`ifdef FAD4_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;

  fad4_seq_arb_if #(.NIB(NIB)) bus ();

  fad4_seq_arb #(.NIB(NIB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic         id;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input bit id, input logic [W-1:0] s, input bit co, input bit ovf);
    exp_t e;
    e.id  = id;
    e.s   = s;
    e.co  = co;
    e.ovf = ovf & OVF_EN;
    sb_q.push_back(e);
  endtask

  task automatic drive_req(input bit id, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      bus.REQ1 = 1'b1; bus.SUB1 = sub; bus.A1_IN = a; bus.B1_IN = b;
    end else begin
      bus.REQ0 = 1'b1; bus.SUB0 = sub; bus.A0_IN = a; bus.B0_IN = b;
    end
  endtask

  task automatic drop_req(input bit id);
    if (id) bus.REQ1 = 1'b0;
    else    bus.REQ0 = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt0"},    32'(bus.GNT0),    32'd0);
    chk({tag, "_gnt1"},    32'(bus.GNT1),    32'd0);
    chk({tag, "_busy"},    32'(bus.BUSY),    32'd0);
    chk({tag, "_done"},    32'(bus.DONE),    32'd0);
    chk({tag, "_done_id"}, 32'(bus.DONE_ID), 32'd0);
    chk({tag, "_s"},       32'(bus.S),       32'd0);
    chk({tag, "_co"},      32'(bus.CO),      32'd0);
    chk({tag, "_ovf"},     32'(bus.OVF),     32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    check_zero("reset");
    RST = 1'b0;
  endtask

  // Single operation starting in the current cycle (cycle 0).
  task automatic do_single(input bit id, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] s, input bit co, input bit ovf);
    push_exp(id, s, co, ovf);
    drive_req(id, sub, a, b);
    tick();                                              // cycle 1
    chk("gnt_own",   32'(id ? bus.GNT1 : bus.GNT0), 32'd1);
    chk("gnt_other", 32'(id ? bus.GNT0 : bus.GNT1), 32'd0);
    chk("busy_run",  32'(bus.BUSY), 32'd1);
    drop_req(id);
    for (int c = 2; c <= NIB; c++) begin
      tick();
      chk("done_early", 32'(bus.DONE), 32'd0);
      chk("busy_run",   32'(bus.BUSY), 32'd1);
    end
    tick();                                              // cycle NIB+1
    chk("done_pulse", 32'(bus.DONE), 32'd1);
    chk("busy_done",  32'(bus.BUSY), 32'd1);
    tick();
    chk("idle_busy", 32'(bus.BUSY), 32'd0);
    chk("idle_done", 32'(bus.DONE), 32'd0);
  endtask

  // REQ0 and REQ1 together in cycle 0; requester 0 must win, then 1 back-to-back.
  task automatic dual_op(input bit sub0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] s0, input bit co0, input bit ovf0,
                         input bit sub1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic [W-1:0] s1, input bit co1, input bit ovf1);
    push_exp(1'b0, s0, co0, ovf0);
    push_exp(1'b1, s1, co1, ovf1);
    drive_req(1'b0, sub0, a0, b0);
    drive_req(1'b1, sub1, a1, b1);
    tick();                                              // cycle 1
    chk("dual_gnt0", 32'(bus.GNT0), 32'd1);
    chk("dual_gnt1_low", 32'(bus.GNT1), 32'd0);
    drop_req(1'b0);
    for (int c = 2; c <= NIB; c++) tick();
    tick();                                              // cycle 5
    chk("dual_done0", 32'(bus.DONE), 32'd1);
    chk("dual_gnt1_wait", 32'(bus.GNT1), 32'd0);
    tick();                                              // cycle 6
    chk("dual_gnt1", 32'(bus.GNT1), 32'd1);
    chk("dual_no_idle", 32'(bus.BUSY), 32'd1);
    drop_req(1'b1);
    for (int c = 2; c <= NIB; c++) tick();
    tick();                                              // cycle 10
    chk("dual_done1", 32'(bus.DONE), 32'd1);
    tick();
    chk("dual_idle", 32'(bus.BUSY), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (bus.DONE === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got DONE id=%0d S=%h, required no DONE (t=%0t)",
                 bus.DONE_ID, bus.S, $time);
      end else begin
        mon_e = sb_q.pop_front();
        $display("DONE id=%0d S=%h CO=%0d OVF=%0d (t=%0t)", bus.DONE_ID, bus.S, bus.CO, bus.OVF, $time);
        chk("done_id", 32'(bus.DONE_ID), 32'(mon_e.id));
        chk("result_s", 32'(bus.S), 32'(mon_e.s));
        chk("result_co", 32'(bus.CO), 32'(mon_e.co));
        chk("result_ovf", 32'(bus.OVF), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0; bus.SUB0 = 1'b0; bus.SUB1 = 1'b0;
    bus.A0_IN = '0; bus.B0_IN = '0; bus.A1_IN = '0; bus.B1_IN = '0;

    // Reset and a plain add from requester 0
    do_reset();
    do_single(1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);

    // Subtraction from requester 1, with and without borrow
    do_single(1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    do_single(1'b1, 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);

    // Wrap-around and signed overflow
    do_single(1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    do_single(1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);

    // Simultaneous requests straight after reset, back-to-back completion
    do_reset();
    dual_op(1'b0, 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0,
            1'b1, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0);

    // Reset in cycle 3 of an operation: no DONE, everything cleared,
    // and the pointer returns to requester 0
    drive_req(1'b0, 1'b0, 16'h4444, 16'h1111);
    tick();                                              // cycle 1
    chk("abort_gnt0", 32'(bus.GNT0), 32'd1);
    drop_req(1'b0);
    tick();                                              // cycle 2
    tick();                                              // cycle 3
    RST = 1'b1;
    tick();                                              // cycle 4
    check_zero("rst_mid");
    RST = 1'b0;
    tick();
    dual_op(1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0,
            1'b0, 16'h0009, 16'h0001, 16'h000A, 1'b0, 1'b0);

    // Both requesters continuously requesting: grants alternate 0,1,0,1
    push_exp(1'b0, 16'h3333, 1'b0, 1'b0);
    push_exp(1'b1, 16'hFFFF, 1'b0, 1'b0);
    push_exp(1'b0, 16'h7FFF, 1'b1, 1'b1);
    push_exp(1'b1, 16'h0000, 1'b1, 1'b0);
    drive_req(1'b0, 1'b0, 16'h1111, 16'h2222);
    drive_req(1'b1, 1'b0, 16'hA5A5, 16'h5A5A);
    for (int i = 0; i < 4; i++) begin
      tick();                                            // cycle 1+5i
      chk("rr_gnt_own",   32'((i % 2) ? bus.GNT1 : bus.GNT0), 32'd1);
      chk("rr_gnt_other", 32'((i % 2) ? bus.GNT0 : bus.GNT1), 32'd0);
      case (i)
        0: drive_req(1'b0, 1'b1, 16'h8000, 16'h0001);
        1: drive_req(1'b1, 1'b1, 16'h0000, 16'h0000);
        2: drop_req(1'b0);
        default: drop_req(1'b1);
      endcase
      for (int c = 2; c <= NIB; c++) tick();
      tick();                                            // cycle 5+5i
      chk("rr_done", 32'(bus.DONE), 32'd1);
    end
    tick();
    chk("rr_idle", 32'(bus.BUSY), 32'd0);

    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
